// File: rtl/fsm_seq_checker.sv
// Read-side checker for the stepping sequencer's state index.
// Predicts the next index, flags deviations, counts laps and resyncs on index 0.
module fsm_seq_checker #(
    parameter int NUM_STATES = 38,
    parameter int STATE_W    = 9,
    parameter int LAP_W      = 8,
    parameter int ERR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    input  logic               clear_err,
    output logic               in_sync,
    output logic               lap_done,
    output logic [LAP_W-1:0]   lap_count,
    output logic               err_pulse,
    output logic               err_sticky,
    output logic [ERR_W-1:0]   err_count
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] OOR_IDX  = STATE_W'(NUM_STATES);

    state_t             state;
    logic [STATE_W-1:0] exp_next;
    logic [STATE_W-1:0] prev_state;
    logic               prev_start;

    logic [STATE_W-1:0] model_next;
    logic               mismatch;
    logic               lap_hit;
    logic [ERR_W-1:0]   err_inc;

    always_comb begin
        model_next = '0;
        if (start && (state_in < LAST_IDX)) begin
            model_next = state_in + STATE_W'(1);
        end
        mismatch = (state_in >= OOR_IDX) || (state_in != exp_next);
        lap_hit  = prev_start && (prev_state == LAST_IDX) && (state_in == '0);
        err_inc  = (err_count == '1) ? err_count : err_count + ERR_W'(1);
    end

    // A mismatch in the same cycle as clear_err restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            exp_next   <= '0;
            prev_state <= '0;
            prev_start <= 1'b0;
            in_sync    <= 1'b0;
            lap_done   <= 1'b0;
            lap_count  <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            exp_next   <= model_next;
            prev_state <= state_in;
            prev_start <= start;
            lap_done   <= 1'b0;
            err_pulse  <= 1'b0;

            if (clear_err) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end

            case (state)
                IDLE, FAULT: begin
                    if (state_in == '0) begin
                        state   <= TRACK;
                        in_sync <= 1'b1;
                    end
                end
                TRACK: begin
                    if (mismatch) begin
                        state      <= FAULT;
                        in_sync    <= 1'b0;
                        err_pulse  <= 1'b1;
                        err_sticky <= 1'b1;
                        err_count  <= clear_err ? ERR_W'(1) : err_inc;
                    end else if (lap_hit) begin
                        lap_done  <= 1'b1;
                        lap_count <= lap_count + LAP_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    in_sync <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Scoreboard bench for fsm_seq_checker: a behavioural model pushes expected
// outputs as each sample is driven, and they are popped and compared next cycle.
module tb_fsm_seq_checker;

    localparam int NS = 38;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] state_in;
    logic       clear_err;
    logic       in_sync;
    logic       lap_done;
    logic [7:0] lap_count;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_count;

    fsm_seq_checker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state_in   (state_in),
        .clear_err  (clear_err),
        .in_sync    (in_sync),
        .lap_done   (lap_done),
        .lap_count  (lap_count),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       in_sync;
        logic       lap_done;
        logic [7:0] lap_count;
        logic       err_pulse;
        logic       err_sticky;
        logic [7:0] err_count;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Behavioural model of the checker: 0 = idle, 1 = tracking, 2 = faulted
    int         m_mode;
    logic [8:0] m_exp;
    logic [8:0] m_prev_s;
    logic       m_prev_st;
    exp_t       m_out;
    logic [8:0] seq_idx;

    task automatic checkOutput(input string tag, input int got, input int want);
        n_compared++;
        if (got != want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [8:0] seq_f(input logic [8:0] s, input logic st);
        if (!st || s >= 9'(NS - 1)) return 9'd0;
        return s + 9'd1;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_exp     = '0;
        m_prev_s  = '0;
        m_prev_st = 1'b0;
        m_out     = '0;
        sb_q.delete();
    endtask

    // Drive one sample at the falling edge, predict, then check after the next rising edge.
    task automatic applyStimulus(input logic [8:0] s, input logic st, input logic clr);
        exp_t e;
        logic err;
        state_in  = s;
        start     = st;
        clear_err = clr;
        err = 1'b0;
        m_out.lap_done  = 1'b0;
        m_out.err_pulse = 1'b0;
        if (m_mode == 1) begin
            if (s >= 9'(NS) || s != m_exp) begin
                err = 1'b1;
                m_mode = 2;
                m_out.in_sync    = 1'b0;
                m_out.err_pulse  = 1'b1;
                m_out.err_sticky = 1'b1;
                if (clr) m_out.err_count = 8'd1;
                else if (m_out.err_count != 8'd255) m_out.err_count = m_out.err_count + 8'd1;
            end else if (m_prev_st && m_prev_s == 9'(NS - 1) && s == 9'd0) begin
                m_out.lap_done  = 1'b1;
                m_out.lap_count = m_out.lap_count + 8'd1;
            end
        end else if (s == 9'd0) begin
            m_mode = 1;
            m_out.in_sync = 1'b1;
        end
        if (clr && !err) begin
            m_out.err_sticky = 1'b0;
            m_out.err_count  = 8'd0;
        end
        m_exp     = seq_f(s, st);
        m_prev_s  = s;
        m_prev_st = st;
        sb_q.push_back(m_out);

        @(negedge clk);
        e = sb_q.pop_front();
        checkOutput("in_sync",    int'(in_sync),    int'(e.in_sync));
        checkOutput("lap_done",   int'(lap_done),   int'(e.lap_done));
        checkOutput("lap_count",  int'(lap_count),  int'(e.lap_count));
        checkOutput("err_pulse",  int'(err_pulse),  int'(e.err_pulse));
        checkOutput("err_sticky", int'(err_sticky), int'(e.err_sticky));
        checkOutput("err_count",  int'(err_count),  int'(e.err_count));
    endtask

    task automatic runClean(input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            applyStimulus(seq_idx, st, 1'b0);
            seq_idx = seq_f(seq_idx, st);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0;
        clear_err = 1'b0;
        state_in = '0;
        model_reset();
        seq_idx = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".in_sync"},    int'(in_sync),    0);
        checkOutput({tag, ".lap_done"},   int'(lap_done),   0);
        checkOutput({tag, ".lap_count"},  int'(lap_count),  0);
        checkOutput({tag, ".err_pulse"},  int'(err_pulse),  0);
        checkOutput({tag, ".err_sticky"}, int'(err_sticky), 0);
        checkOutput({tag, ".err_count"},  int'(err_count),  0);
    endtask

    initial begin
        doReset();
        checkAllZero("reset");

        // Clean run: two laps in 80 samples
        runClean(80, 1'b1);
        checkOutput("clean.lap_count", int'(lap_count), 2);
        checkOutput("clean.err_count", int'(err_count), 0);
        checkOutput("clean.in_sync",   int'(in_sync),   1);

        // Skip 12 -> 14
        runClean(8, 1'b1);
        runClean(1, 1'b1);
        applyStimulus(9'd14, 1'b1, 1'b0);
        checkOutput("skip.err_pulse",  int'(err_pulse),  1);
        checkOutput("skip.err_sticky", int'(err_sticky), 1);
        checkOutput("skip.err_count",  int'(err_count),  1);
        checkOutput("skip.in_sync",    int'(in_sync),    0);
        applyStimulus(9'd15, 1'b1, 1'b0);
        checkOutput("skip.pulse_once", int'(err_pulse), 0);
        applyStimulus(9'd0, 1'b0, 1'b0);
        applyStimulus(9'd0, 1'b0, 1'b0);
        checkOutput("skip.resync", int'(in_sync),   1);
        checkOutput("skip.no_more", int'(err_count), 1);

        // Out-of-range index while tracking, then ignored while faulted
        seq_idx = '0;
        runClean(5, 1'b1);
        applyStimulus(9'd40, 1'b1, 1'b0);
        checkOutput("oor.err_count", int'(err_count), 2);
        applyStimulus(9'd5, 1'b1, 1'b0);
        checkOutput("oor.fault_quiet", int'(err_pulse), 0);
        applyStimulus(9'd0, 1'b1, 1'b0);
        checkOutput("oor.resync", int'(in_sync), 1);

        // start drops at index 20: back to 0 with no error and no lap
        seq_idx = 9'd1;
        runClean(19, 1'b1);
        applyStimulus(9'd20, 1'b0, 1'b0);
        applyStimulus(9'd0, 1'b0, 1'b0);
        checkOutput("drop.lap_done",  int'(lap_done),  0);
        checkOutput("drop.lap_count", int'(lap_count), 2);
        checkOutput("drop.err_count", int'(err_count), 2);

        // clear_err colliding with a mismatch, then clear_err alone
        applyStimulus(9'd7, 1'b1, 1'b0);
        checkOutput("clr.pre_count", int'(err_count), 3);
        applyStimulus(9'd0, 1'b1, 1'b0);
        applyStimulus(9'd1, 1'b1, 1'b0);
        applyStimulus(9'd9, 1'b1, 1'b1);
        checkOutput("clr.collide_count",  int'(err_count),  1);
        checkOutput("clr.collide_sticky", int'(err_sticky), 1);
        applyStimulus(9'd0, 1'b0, 1'b1);
        checkOutput("clr.alone_count",  int'(err_count),  0);
        checkOutput("clr.alone_sticky", int'(err_sticky), 0);

        // 260 laps wrap the lap counter to 4
        doReset();
        runClean(260 * NS + 1, 1'b1);
        checkOutput("wrap.lap_count", int'(lap_count), 4);

        // 300 induced faults saturate the error counter
        for (int i = 0; i < 300; i++) begin
            applyStimulus(9'd5, 1'b1, 1'b0);
            applyStimulus(9'd0, 1'b1, 1'b0);
        end
        checkOutput("sat.err_count", int'(err_count), 255);

        // Asynchronous reset mid-lap clears outputs before the next rising edge
        seq_idx = 9'd1;
        runClean(10, 1'b1);
        #2 rst = 1'b1;
        #1 checkAllZero("async_rst");
        model_reset();
        seq_idx = '0;
        @(negedge clk);
        rst = 1'b0;
        runClean(3, 1'b1);
        checkOutput("post_rst.in_sync", int'(in_sync), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
